// File: rtl/scara_pkg.sv
// Shared types and widths for the SCARA step pulse generator.
// Holds the FSM state encoding and the per-axis move planning helper.
package scara_pkg;

  localparam int POS_W = 14;
  localparam int TMR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PULSE_HI = 3'd2,
    ST_PULSE_LO = 3'd3,
    ST_FINISH   = 3'd4
  } state_e;

  typedef struct packed {
    logic             dir;
    logic [POS_W-1:0] rem;
  } plan_t;

  // Direction and step count to travel from pos to tgt. A zero-length move
  // reports dir = 0.
  function automatic plan_t plan_move(input logic [POS_W-1:0] tgt,
                                      input logic [POS_W-1:0] pos);
    logic signed [POS_W:0] diff;
    logic signed [POS_W:0] neg_diff;
    plan_t                 p;
    diff     = $signed({1'b0, tgt}) - $signed({1'b0, pos});
    neg_diff = -diff;
    p.dir    = (diff > 0);
    p.rem    = diff[POS_W] ? neg_diff[POS_W-1:0] : diff[POS_W-1:0];
    return p;
  endfunction

endpackage

// File: rtl/step_axis.sv
// One joint axis: latches its target, plans direction/remaining steps,
// tracks absolute position and drives its STEP output.
module step_axis
  import scara_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_accept,
  input  logic [POS_W-1:0] i_tgt,
  input  logic             i_load,
  input  logic             i_rise,
  input  logic             i_fall,
  input  logic             i_clear,
  output logic             o_step,
  output logic             o_dir,
  output logic [POS_W-1:0] o_pos,
  output logic             o_rem_nz
);

  logic [POS_W-1:0] r_tgt;
  logic [POS_W-1:0] r_rem;
  logic [POS_W-1:0] r_pos;
  logic             r_dir;
  logic             r_step;
  plan_t            w_plan;

  assign w_plan = plan_move(r_tgt, r_pos);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tgt  <= '0;
      r_rem  <= '0;
      r_pos  <= '0;
      r_dir  <= 1'b0;
      r_step <= 1'b0;
    end else begin
      if (i_accept) begin
        r_tgt <= i_tgt;
      end
      if (i_load) begin
        r_dir <= w_plan.dir;
        r_rem <= w_plan.rem;
      end else if (i_clear) begin
        // Steps left over from a halted move are dropped; r_pos stays true.
        r_rem <= '0;
      end else if (i_rise && (r_rem != '0)) begin
        r_step <= 1'b1;
        r_pos  <= r_dir ? (r_pos + 1'b1) : (r_pos - 1'b1);
        r_rem  <= r_rem - 1'b1;
      end
      if (i_fall) begin
        r_step <= 1'b0;
      end
    end
  end

  // During the load cycle the registered count is stale, so look ahead.
  assign o_rem_nz = i_load ? (w_plan.rem != '0) : (r_rem != '0);
  assign o_step   = r_step;
  assign o_dir    = r_dir;
  assign o_pos    = r_pos;

endmodule

// File: rtl/step_pulse_gen.sv
// Two-axis STEP/DIR pulse generator: one move FSM and phase timer shared by
// two step_axis instances that pulse concurrently at a common period.
module step_pulse_gen
  import scara_pkg::*;
#(
  parameter int PULSE_HI_CYC  = 50,
  parameter int PULSE_PER_CYC = 500,
  parameter int DIR_SETUP_CYC = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [POS_W-1:0] th1_steps,
  input  logic [POS_W-1:0] th2_steps,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic             halt,
  output logic             step1,
  output logic             step2,
  output logic             dir1,
  output logic             dir2,
  output logic [POS_W-1:0] pos1,
  output logic [POS_W-1:0] pos2,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state
);

  // Handshake: a target is taken on a rising clk edge where tgt_valid and
  // tgt_ready are both 1; tgt_ready is 1 only while idle, and tgt_valid
  // at any other time is ignored.

  // SETUP spends its first cycle planning (dir/remaining load), then holds
  // DIR steady for DIR_SETUP_CYC cycles; DIR_SETUP_CYC and PULSE_HI_CYC >= 1.
  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(DIR_SETUP_CYC);
  localparam logic [TMR_W-1:0] HI_LAST    = TMR_W'(PULSE_HI_CYC - 1);
  localparam logic [TMR_W-1:0] LO_LAST    = TMR_W'(PULSE_PER_CYC - PULSE_HI_CYC - 1);

  state_e           r_state;
  state_e           w_next;
  logic [TMR_W-1:0] r_timer;
  logic             r_ready;
  logic             r_halt_pend;

  logic w_accept;
  logic w_load;
  logic w_rise;
  logic w_fall;
  logic w_clear;
  logic w_stop;
  logic w_nz1;
  logic w_nz2;
  logic w_rem_any;

  assign w_accept  = tgt_valid & r_ready;
  assign w_rem_any = w_nz1 | w_nz2;
  assign w_stop    = halt | r_halt_pend;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (halt) begin
          w_next = ST_FINISH;
        end else if (r_timer == SETUP_LAST) begin
          w_next = w_rem_any ? ST_PULSE_HI : ST_FINISH;
        end
      end
      ST_PULSE_HI: begin
        if (r_timer == HI_LAST) w_next = ST_PULSE_LO;
      end
      ST_PULSE_LO: begin
        if (r_timer == LO_LAST) begin
          w_next = (w_rem_any && !w_stop) ? ST_PULSE_HI : ST_FINISH;
        end
      end
      ST_FINISH: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_load  = (r_state == ST_SETUP) && (r_timer == '0);
  assign w_rise  = (w_next == ST_PULSE_HI) && (r_state != ST_PULSE_HI);
  assign w_fall  = (r_state == ST_PULSE_HI) && (w_next != ST_PULSE_HI);
  assign w_clear = (r_state == ST_FINISH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_ready     <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE);
      if ((r_state == ST_IDLE) || (w_next != r_state)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
      // A halt seen mid-pulse is remembered until the low phase finishes.
      if ((r_state == ST_PULSE_HI || r_state == ST_PULSE_LO) && halt) begin
        r_halt_pend <= 1'b1;
      end else if (r_state == ST_FINISH || r_state == ST_IDLE) begin
        r_halt_pend <= 1'b0;
      end
    end
  end

  step_axis u_axis1 (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_accept (w_accept),
    .i_tgt    (th1_steps),
    .i_load   (w_load),
    .i_rise   (w_rise),
    .i_fall   (w_fall),
    .i_clear  (w_clear),
    .o_step   (step1),
    .o_dir    (dir1),
    .o_pos    (pos1),
    .o_rem_nz (w_nz1)
  );

  step_axis u_axis2 (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_accept (w_accept),
    .i_tgt    (th2_steps),
    .i_load   (w_load),
    .i_rise   (w_rise),
    .i_fall   (w_fall),
    .i_clear  (w_clear),
    .o_step   (step2),
    .o_dir    (dir2),
    .o_pos    (pos2),
    .o_rem_nz (w_nz2)
  );

  assign tgt_ready = r_ready;
  assign busy      = (r_state == ST_SETUP) || (r_state == ST_PULSE_HI) ||
                     (r_state == ST_PULSE_LO);
  assign done      = (r_state == ST_FINISH);
  assign dbg_state = r_state;

endmodule
